// File: rtl/cordic_sincos_engine.sv
// Iterative rotation-mode CORDIC: cos/sin of a signed Q8.24 degree angle.
// One micro-rotation per clock, driven by an external combinational
// arctangent table (lut_sel -> lut_value). Results are Q2.30.
module cordic_sincos_engine #(
  parameter int          N_ITER = 15,
  parameter logic [31:0] K_INIT = 32'h26DD3B6A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_angle,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_cos,
  output logic [31:0] out_sin,
  output logic        out_err,
  output logic        lut_en,
  output logic [3:0]  lut_sel,
  input  logic [31:0] lut_value
);

  typedef enum logic [2:0] {S_INIT, S_WARM, S_IDLE, S_ITER, S_DONE} state_e;

  localparam logic signed [31:0] MAX_ANG = 32'sh5A000000;  // 90.0 deg
  localparam logic [3:0]         LAST_I  = 4'(N_ITER - 1);

  state_e      state_q;
  logic [31:0] x_q, y_q, z_q;
  logic [31:0] x_d, y_d, z_d;
  logic [31:0] x_sh, y_sh;
  logic [3:0]  i_q;
  logic        in_ready_q, out_valid_q, out_err_q, lut_en_q;
  logic [31:0] out_cos_q, out_sin_q;
  logic        angle_ok, rot_pos;

  // Range gate; signed compare also rejects 32'h80000000 (most negative).
  assign angle_ok = ($signed(in_angle) <= MAX_ANG) && ($signed(in_angle) >= -MAX_ANG);

  // One micro-rotation; direction taken from the sign of the residual angle.
  always_comb begin
    rot_pos = ~z_q[31];
    x_sh    = 32'($signed(x_q) >>> i_q);
    y_sh    = 32'($signed(y_q) >>> i_q);
    x_d     = rot_pos ? (x_q - y_sh)      : (x_q + y_sh);
    y_d     = rot_pos ? (y_q + x_sh)      : (y_q - x_sh);
    z_d     = rot_pos ? (z_q - lut_value) : (z_q + lut_value);
  end

  // Control FSM plus datapath registers; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      i_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_cos_q   <= '0;
      out_sin_q   <= '0;
      lut_en_q    <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          lut_en_q <= 1'b1;
          state_q  <= S_WARM;
        end
        S_WARM: begin
          // Table has had one cycle enabled before the first angle arrives.
          in_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (angle_ok) begin
              x_q     <= K_INIT;
              y_q     <= '0;
              z_q     <= in_angle;
              i_q     <= '0;
              state_q <= S_ITER;
            end else begin
              out_cos_q   <= '0;
              out_sin_q   <= '0;
              out_err_q   <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_ITER: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          if (i_q == LAST_I) begin
            // i_q doubles as lut_sel, so park it at 0 outside ITER.
            i_q         <= '0;
            out_cos_q   <= x_d;
            out_sin_q   <= y_d;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            i_q <= i_q + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign out_cos   = out_cos_q;
  assign out_sin   = out_sin_q;
  assign lut_en    = lut_en_q;
  assign lut_sel   = i_q;

endmodule

// File: tb/tb_cordic_sincos_engine.sv
// Directed bench for cordic_sincos_engine with a behavioural arctangent table.
module tb_cordic_sincos_engine;

  localparam real PI = 3.14159265358979323846;
  localparam int  TOL = 32'h20000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_err, lut_en;
  logic [31:0] in_angle, out_cos, out_sin, lut_value;
  logic [3:0]  lut_sel;
  logic [31:0] tbl [16];

  int n_chk = 0;
  int n_err = 0;

  cordic_sincos_engine dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cos(out_cos), .out_sin(out_sin), .out_err(out_err),
    .lut_en(lut_en), .lut_sel(lut_sel), .lut_value(lut_value)
  );

  always #5 clk = ~clk;

  // atan(2^-i) in degrees, Q8.24, combinational from lut_sel
  initial for (int i = 0; i < 16; i++)
    tbl[i] = 32'($rtoi($atan(2.0 ** (-i)) * 180.0 / PI * 16777216.0 + 0.5));
  assign lut_value = lut_en ? tbl[lut_sel] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp, input int tol);
    longint d;
    d = longint'($signed(got)) - longint'($signed(exp));
    if (d < 0) d = -d;
    n_chk++;
    if (d > longint'(tol)) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (tol %0h)", tag, got, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reset, then check INIT/WARM release timing.
  task automatic reset_seq(input string tag);
    rst_n = 1'b0;
    repeat (2) tick();
    chk({tag, "_rst_lut_en"},   32'(lut_en),    32'h0, 0);
    chk({tag, "_rst_in_ready"}, 32'(in_ready),  32'h0, 0);
    chk({tag, "_rst_out_valid"},32'(out_valid), 32'h0, 0);
    chk({tag, "_rst_lut_sel"},  32'(lut_sel),   32'h0, 0);
    rst_n = 1'b1;
    tick();
    chk({tag, "_e1_lut_en"},   32'(lut_en),   32'h1, 0);
    chk({tag, "_e1_in_ready"}, 32'(in_ready), 32'h0, 0);
    tick();
    chk({tag, "_e2_in_ready"}, 32'(in_ready), 32'h1, 0);
    chk({tag, "_e2_lut_en"},   32'(lut_en),   32'h1, 0);
  endtask

  // Offer an angle, wait for out_valid (bounded), leave result un-acked.
  task automatic issue(input string tag, input logic [31:0] ang, input int exp_lat);
    int lat;
    chk({tag, "_pre_in_ready"}, 32'(in_ready), 32'h1, 0);
    in_valid = 1'b1; in_angle = ang;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat), 0);
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ack_out_valid"}, 32'(out_valid), 32'h0, 0);
    chk({tag, "_ack_in_ready"},  32'(in_ready),  32'h1, 0);
  endtask

  task automatic run(input string tag, input logic [31:0] ang,
                     input logic [31:0] ecos, input logic [31:0] esin,
                     input logic eerr, input int tol);
    issue(tag, ang, eerr ? 0 : 15);
    chk({tag, "_cos"}, out_cos, ecos, tol);
    chk({tag, "_sin"}, out_sin, esin, tol);
    chk({tag, "_err"}, 32'(out_err), 32'(eerr), 0);
    ack(tag);
  endtask

  initial begin
    in_valid = 1'b0; in_angle = '0; out_ready = 1'b0;
    // T1
    reset_seq("t1");
    // T2
    run("t2_zero", 32'h00000000, 32'h40000000, 32'h00000000, 1'b0, TOL);
    // T3
    run("t3_p30", 32'h1E000000, 32'h376CF5D1, 32'h20000000, 1'b0, TOL);
    run("t3_m30", 32'hE2000000, 32'h376CF5D1, 32'hE0000000, 1'b0, TOL);
    // T4
    run("t4_p90", 32'h5A000000, 32'h00000000, 32'h40000000, 1'b0, TOL);
    run("t4_m90", 32'hA6000000, 32'h00000000, 32'hC0000000, 1'b0, TOL);
    run("t4_over", 32'h5A000001, 32'h00000000, 32'h00000000, 1'b1, 0);
    run("t4_min",  32'h80000000, 32'h00000000, 32'h00000000, 1'b1, 0);
    run("t4_after_err", 32'h2D000000, 32'h2D413CCD, 32'h2D413CCD, 1'b0, TOL);

    // T5: stall in DONE, in_valid pulses must be ignored
    issue("t5", 32'h1E000000, 15);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0]; in_angle = 32'h00000000;
      chk("t5_hold_valid", 32'(out_valid), 32'h1, 0);
      chk("t5_hold_ready", 32'(in_ready),  32'h0, 0);
      chk("t5_hold_cos",   out_cos, 32'h376CF5D1, TOL);
      chk("t5_hold_sin",   out_sin, 32'h20000000, TOL);
      tick();
    end
    in_valid = 1'b0;
    chk("t5_end_cos", out_cos, 32'h376CF5D1, TOL);
    ack("t5");
    chk("t5_kept_cos", out_cos, 32'h376CF5D1, TOL);
    run("t5_next", 32'hE2000000, 32'h376CF5D1, 32'hE0000000, 1'b0, TOL);

    // T6: asynchronous abort while iteration 7 is in progress
    in_valid = 1'b1; in_angle = 32'h1E000000;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    chk("t6_mid_sel", 32'(lut_sel), 32'h7, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_lut_en",   32'(lut_en),   32'h0, 0);
    chk("t6_async_in_ready", 32'(in_ready), 32'h0, 0);
    chk("t6_async_valid",    32'(out_valid),32'h0, 0);
    chk("t6_async_err",      32'(out_err),  32'h0, 0);
    chk("t6_async_cos",      out_cos,       32'h0, 0);
    chk("t6_async_sin",      out_sin,       32'h0, 0);
    chk("t6_async_sel",      32'(lut_sel),  32'h0, 0);
    reset_seq("t6");
    run("t6_p45", 32'h2D000000, 32'h2D413CCD, 32'h2D413CCD, 1'b0, TOL);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
